// File: rtl/ixu_pkg.sv
// Shared widths and the scheduler entry layout for the integer execution unit.
package ixu_pkg;

    localparam int PREG_W = 6;
    localparam int ROB_W  = 6;
    localparam int PKT_W  = 2 * PREG_W + ROB_W;

    typedef struct packed {
        logic              valid;
        logic [ROB_W-1:0]  rob;
        logic [PREG_W-1:0] rs1;
        logic [PREG_W-1:0] rs2;
        logic              rs1_rdy;
        logic              rs2_rdy;
    } sched_entry_t;

endpackage

// File: rtl/ixu_sched_select.sv
// Fixed-priority select: grants the lowest-index requester, one-hot plus encoded index.
module ixu_sched_select #(
    parameter int N = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !gnt_valid) begin
                gnt[i]    = 1'b1;
                gnt_idx   = IDX_W'(i);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ixu_sc_sched.sv
// Age-ordered collapsing issue queue for the single-cycle pipe, with
// combinational wake bypass into select and a registered issue packet.
module ixu_sc_sched
    import ixu_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int WAKE_PORTS = 3,
    localparam int CNT_W     = $clog2(DEPTH) + 1,
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic                               core_clock_i,
    input  logic                               core_reset_ni,
    input  logic                               core_flush_i,
    input  logic [1:0]                         enq_valid_i,
    input  logic [1:0][ROB_W-1:0]              enq_rob_i,
    input  logic [1:0][PREG_W-1:0]             enq_rs1_i,
    input  logic [1:0][PREG_W-1:0]             enq_rs2_i,
    input  logic [1:0]                         enq_rs1_rdy_i,
    input  logic [1:0]                         enq_rs2_rdy_i,
    output logic                               enq_ready_o,
    input  logic [WAKE_PORTS-1:0][PREG_W-1:0]  wake_dest_i,
    input  logic [WAKE_PORTS-1:0]              wake_valid_i,
    output logic [PKT_W-1:0]                   data_o,
    output logic                               valid_o,
    output logic [CNT_W-1:0]                   occupancy_o
);

    sched_entry_t     q       [DEPTH];
    sched_entry_t     upd     [DEPTH+1];
    sched_entry_t     q_nxt   [DEPTH];
    sched_entry_t     new_ent [2];
    logic [DEPTH-1:0] req;
    logic [DEPTH-1:0] gnt;
    logic [DEPTH-1:0] shift;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_valid;
    logic [CNT_W-1:0] occ;
    logic [CNT_W-1:0] surv;
    logic [CNT_W-1:0] slot0;
    logic [CNT_W-1:0] slot1;
    logic [1:0]       acc;

    // Physical register 0 is hardwired ready.
    function automatic logic woken(input logic [PREG_W-1:0]                  src,
                                   input logic [WAKE_PORTS-1:0][PREG_W-1:0]  dest,
                                   input logic [WAKE_PORTS-1:0]              vld);
        logic hit;
        hit = (src == '0);
        for (int k = 0; k < WAKE_PORTS; k++) begin
            hit = hit | (vld[k] && (dest[k] == src));
        end
        return hit;
    endfunction

    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            upd[i]         = q[i];
            upd[i].rs1_rdy = q[i].rs1_rdy | woken(q[i].rs1, wake_dest_i, wake_valid_i);
            upd[i].rs2_rdy = q[i].rs2_rdy | woken(q[i].rs2, wake_dest_i, wake_valid_i);
            req[i]         = q[i].valid & upd[i].rs1_rdy & upd[i].rs2_rdy;
            occ            = occ + CNT_W'(q[i].valid);
        end
        upd[DEPTH] = '0;
    end

    assign occupancy_o = occ;
    assign enq_ready_o = (occ <= CNT_W'(DEPTH - 2));

    ixu_sched_select #(.N(DEPTH)) u_select (
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (sel_idx),
        .gnt_valid (sel_valid)
    );

    // Slots at and above the granted one take their younger neighbour.
    always_comb begin
        logic run;
        run   = 1'b0;
        shift = '0;
        for (int i = 0; i < DEPTH; i++) begin
            run      = run | gnt[i];
            shift[i] = run;
        end
    end

    always_comb begin
        acc   = enq_valid_i & {2{enq_ready_o}};
        surv  = occ - CNT_W'(sel_valid);
        slot0 = surv;
        slot1 = surv + CNT_W'(acc[0]);
        for (int l = 0; l < 2; l++) begin
            new_ent[l] = '{valid:   1'b1,
                           rob:     enq_rob_i[l],
                           rs1:     enq_rs1_i[l],
                           rs2:     enq_rs2_i[l],
                           rs1_rdy: enq_rs1_rdy_i[l] | woken(enq_rs1_i[l], wake_dest_i, wake_valid_i),
                           rs2_rdy: enq_rs2_rdy_i[l] | woken(enq_rs2_i[l], wake_dest_i, wake_valid_i)};
        end
        for (int i = 0; i < DEPTH; i++) begin
            q_nxt[i] = shift[i] ? upd[i+1] : upd[i];
            if (acc[0] && (slot0 == CNT_W'(i))) q_nxt[i] = new_ent[0];
            if (acc[1] && (slot1 == CNT_W'(i))) q_nxt[i] = new_ent[1];
        end
    end

    always_ff @(posedge core_clock_i) begin
        if (!core_reset_ni) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (core_flush_i) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            valid_o <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
            valid_o <= sel_valid;
            if (sel_valid) data_o <= {q[sel_idx].rs2, q[sel_idx].rs1, q[sel_idx].rob};
        end
    end

endmodule

// File: tb/tb_ixu_sc_sched.sv
// Directed bench for ixu_sc_sched: stimulus queues expected issue packets,
// a negedge monitor pops and compares them whenever valid_o is high.
module tb_ixu_sc_sched;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic [1:0]       enq_valid;
    logic [1:0][5:0]  enq_rob;
    logic [1:0][5:0]  enq_rs1;
    logic [1:0][5:0]  enq_rs2;
    logic [1:0]       enq_rs1_rdy;
    logic [1:0]       enq_rs2_rdy;
    logic             enq_ready;
    logic [2:0][5:0]  wake_dest;
    logic [2:0]       wake_valid;
    logic [17:0]      data;
    logic             valid;
    logic [3:0]       occ;

    int checks   = 0;
    int failures = 0;
    logic [17:0] exp_q [$];

    ixu_sc_sched #(.DEPTH(8), .WAKE_PORTS(3)) dut (
        .core_clock_i  (clk),
        .core_reset_ni (rst_n),
        .core_flush_i  (flush),
        .enq_valid_i   (enq_valid),
        .enq_rob_i     (enq_rob),
        .enq_rs1_i     (enq_rs1),
        .enq_rs2_i     (enq_rs2),
        .enq_rs1_rdy_i (enq_rs1_rdy),
        .enq_rs2_rdy_i (enq_rs2_rdy),
        .enq_ready_o   (enq_ready),
        .wake_dest_i   (wake_dest),
        .wake_valid_i  (wake_valid),
        .data_o        (data),
        .valid_o       (valid),
        .occupancy_o   (occ)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic clr_in();
        flush       = 1'b0;
        enq_valid   = '0;
        enq_rob     = '0;
        enq_rs1     = '0;
        enq_rs2     = '0;
        enq_rs1_rdy = '0;
        enq_rs2_rdy = '0;
        wake_dest   = '0;
        wake_valid  = '0;
    endtask

    task automatic set_lane(input int l, input int rob, input int rs1, input int r1,
                            input int rs2, input int r2);
        enq_valid[l]   = 1'b1;
        enq_rob[l]     = 6'(rob);
        enq_rs1[l]     = 6'(rs1);
        enq_rs2[l]     = 6'(rs2);
        enq_rs1_rdy[l] = (r1 != 0);
        enq_rs2_rdy[l] = (r2 != 0);
    endtask

    task automatic wake(input int p, input int d);
        wake_dest[p]  = 6'(d);
        wake_valid[p] = 1'b1;
    endtask

    task automatic push(input int rob, input int rs1, input int rs2);
        exp_q.push_back({6'(rs2), 6'(rs1), 6'(rob)});
    endtask

    // Monitor: every issued packet must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [17:0] e;
        if (valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL issue_unexpected got=%h want=none", data);
            end else begin
                e = exp_q.pop_front();
                if (data !== e) begin
                    failures++;
                    $display("FAIL issue_data got=%h want=%h", data, e);
                end
            end
        end
    end

    initial begin
        clr_in();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(valid), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_occ", 32'(occ), 0);
        rst_n = 1'b1;
        tick();
        chk("rst_enq_ready", 32'(enq_ready), 1);

        // Basic two-cycle enqueue-to-issue latency.
        set_lane(0, 3, 5, 1, 0, 0);
        push(3, 5, 0);
        tick();
        clr_in();
        chk("s1_occ_after_enq", 32'(occ), 1);
        chk("s1_no_early_issue", 32'(valid), 0);
        tick();
        chk("s1_valid_2cyc", 32'(valid), 1);
        chk("s1_occ_drained", 32'(occ), 0);
        tick();
        chk("s1_valid_drop", 32'(valid), 0);

        // Wake bypass, wake qualifier, and older-ready-first.
        set_lane(0, 13, 9, 0, 0, 0);
        tick();
        clr_in();
        wake_dest[1] = 6'd9;
        tick();
        chk("s2_unqualified_wake", 32'(valid), 0);
        wake(1, 9);
        push(13, 9, 0);
        tick();
        clr_in();
        chk("s2_wake_issue_t1", 32'(valid), 1);
        tick();
        chk("s2_idle", 32'(valid), 0);

        set_lane(0, 12, 1, 1, 2, 1);
        set_lane(1, 10, 9, 0, 0, 0);
        tick();
        clr_in();
        wake(1, 9);
        push(12, 1, 2);
        push(10, 9, 0);
        tick();
        clr_in();
        chk("s2_older_wins", 32'(valid), 1);
        tick();
        chk("s2_woken_next", 32'(valid), 1);
        tick();
        chk("s2_drained", 32'(occ), 0);

        set_lane(0, 14, 20, 0, 0, 0);
        wake(2, 20);
        push(14, 20, 0);
        tick();
        clr_in();
        chk("s2_enq_wake_no_early", 32'(valid), 0);
        tick();
        chk("s2_enq_wake_issue", 32'(valid), 1);

        set_lane(0, 15, 0, 0, 21, 0);
        tick();
        clr_in();
        tick();
        chk("s2_rs2_wait", 32'(valid), 0);
        wake(0, 21);
        push(15, 0, 21);
        tick();
        clr_in();
        chk("s2_rs2_wake_issue", 32'(valid), 1);
        tick();

        // Fill to full, back-pressure, and age order across the collapse.
        for (int c = 0; c < 4; c++) begin
            chk("s3_ready_while_filling", 32'(enq_ready), 1);
            set_lane(0, 20 + 2 * c, 30 + 2 * c, 0, 0, 0);
            set_lane(1, 21 + 2 * c, 31 + 2 * c, 0, 0, 0);
            tick();
        end
        clr_in();
        chk("s3_full_occ", 32'(occ), 8);
        chk("s3_full_not_ready", 32'(enq_ready), 0);
        wake(1, 33);
        set_lane(0, 40, 0, 1, 0, 1);
        push(23, 33, 0);
        tick();
        clr_in();
        chk("s3_full_enq_rejected", 32'(occ), 7);
        chk("s3_ready_at_7", 32'(enq_ready), 0);
        wake(0, 30);
        push(20, 30, 0);
        tick();
        clr_in();
        chk("s3_occ_6", 32'(occ), 6);
        chk("s3_ready_at_6", 32'(enq_ready), 1);
        wake(0, 37);
        wake(1, 31);
        wake(2, 35);
        push(21, 31, 0);
        push(25, 35, 0);
        push(27, 37, 0);
        tick();
        clr_in();
        tick();
        tick();
        chk("s3_occ_3", 32'(occ), 3);
        wake(0, 36);
        wake(1, 32);
        wake(2, 34);
        push(22, 32, 0);
        push(24, 34, 0);
        push(26, 36, 0);
        tick();
        clr_in();
        tick();
        tick();
        chk("s3_occ_0", 32'(occ), 0);
        tick();

        // Three ready entries issue back to back in age order; lane-1-only enqueue.
        set_lane(0, 1, 0, 1, 0, 1);
        set_lane(1, 2, 0, 1, 0, 1);
        push(1, 0, 0);
        push(2, 0, 0);
        push(3, 0, 0);
        tick();
        clr_in();
        set_lane(0, 3, 0, 1, 0, 1);
        tick();
        clr_in();
        chk("s4_issue1", 32'(valid), 1);
        tick();
        chk("s4_issue2", 32'(valid), 1);
        tick();
        chk("s4_issue3", 32'(valid), 1);
        tick();
        chk("s4_idle", 32'(valid), 0);
        set_lane(1, 5, 0, 1, 0, 1);
        push(5, 0, 0);
        tick();
        clr_in();
        chk("s4_lane1_occ", 32'(occ), 1);
        tick();
        chk("s4_lane1_issue", 32'(valid), 1);

        // Flush with five entries, a pending selection and a same-cycle enqueue.
        set_lane(0, 50, 40, 0, 0, 0);
        set_lane(1, 51, 41, 0, 0, 0);
        tick();
        set_lane(0, 52, 42, 0, 0, 0);
        set_lane(1, 53, 43, 0, 0, 0);
        tick();
        clr_in();
        set_lane(0, 54, 44, 0, 0, 0);
        tick();
        clr_in();
        chk("s5_occ_5", 32'(occ), 5);
        flush = 1'b1;
        wake(0, 40);
        set_lane(0, 60, 0, 1, 0, 1);
        tick();
        clr_in();
        chk("s5_flush_valid", 32'(valid), 0);
        chk("s5_flush_occ", 32'(occ), 0);
        tick();
        chk("s5_dropped_enq", 32'(valid), 0);
        chk("s5_occ_stays_0", 32'(occ), 0);

        // Reset mid-stream discards a ready and a waiting entry.
        set_lane(0, 63, 0, 1, 0, 1);
        set_lane(1, 61, 45, 0, 0, 0);
        tick();
        clr_in();
        rst_n = 1'b0;
        tick();
        chk("s6_rst_valid", 32'(valid), 0);
        chk("s6_rst_data", 32'(data), 0);
        chk("s6_rst_occ", 32'(occ), 0);
        rst_n = 1'b1;
        chk("s6_enq_ready", 32'(enq_ready), 1);
        wake(0, 45);
        tick();
        clr_in();
        tick();
        tick();
        chk("s6_no_stale", 32'(valid), 0);

        tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ixu_sc_sched.md
IXU_SC_SCHED -- requirements
Module: ixu_sc_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of scheduler entries (power of two, 4..16).
REQ-002 SHALL have parameter WAKE_PORTS, default 3, number of wakeup broadcast ports.
REQ-003 SHALL have port core_clock_i, input, 1, the single clock.
REQ-004 SHALL have port core_reset_ni, input, 1, the reset: synchronous and active-low.
REQ-005 SHALL have port core_flush_i, input, 1, pipeline flush that discards all entries.
REQ-006 SHALL have port enq_valid_i, input, 2, per-lane enqueue request; lane 0 is older than lane 1.
REQ-007 SHALL have ports enq_rob_i, enq_rs1_i and enq_rs2_i, input, 2x6 each, ROB tag and physical sources per lane.
REQ-008 SHALL have ports enq_rs1_rdy_i and enq_rs2_rdy_i, input, 2 each, source-ready-at-rename per lane.
REQ-009 SHALL have port enq_ready_o, output, 1, high when at least 2 entries are free.
REQ-010 SHALL have port wake_dest_i, input, WAKE_PORTS x6, broadcast destination physical register.
REQ-011 SHALL have port wake_valid_i, input, WAKE_PORTS, qualifier for each wake_dest_i.
REQ-012 SHALL have port data_o, output, 18, issued packet {rs2[5:0], rs1[5:0], rob[5:0]} for the single-cycle pipe.
REQ-013 SHALL have port valid_o, output, 1, issued packet valid.
REQ-014 SHALL have port occupancy_o, output, $clog2(DEPTH)+1, count of valid entries.

Function
REQ-015 Each entry SHALL hold: valid, rob, rs1, rs2, rs1_rdy and rs2_rdy.
REQ-016 Entries SHALL be age-ordered by a collapsing queue; index 0 is oldest.
REQ-017 An entry's source SHALL become ready when any wake_valid_i[k] is high with wake_dest_i[k] equal to that source.
REQ-018 Physical register 0 SHALL always be treated as ready.
REQ-019 Select SHALL use combinational wake bypass: an entry whose last source wakes in cycle t is selectable in cycle t.
REQ-020 Each cycle, select SHALL pick the lowest-index valid entry with both sources ready (after bypass); at most one entry is selected per cycle.
REQ-021 data_o and valid_o SHALL be registered: a selection in cycle t appears on data_o/valid_o in cycle t+1.
REQ-022 valid_o SHALL be 0 in any cycle that follows a cycle with no selection.
REQ-023 The selected entry SHALL be removed, and younger entries SHALL shift down one slot in the same cycle.
REQ-024 Enqueue SHALL be accepted only when enq_ready_o is high.
REQ-025 enq_ready_o SHALL be computed from the occupancy at the start of the cycle; it does not credit a same-cycle issue.
REQ-026 Accepted lanes SHALL be appended after all surviving entries, lane 0 first; with only lane 1 valid, lane 1 takes the first free slot.
REQ-027 Enqueued ready bits SHALL be OR-ed with same-cycle wake matches.
REQ-028 A new entry SHALL be selectable no earlier than the cycle after enqueue.
REQ-029 Issue and enqueue in the same cycle SHALL both complete, and occupancy SHALL change by (enqueued - 1).
REQ-030 Flush SHALL clear all entry valids and force valid_o=0 on the next cycle; enqueue is ignored in the flush cycle.
REQ-031 Flush SHALL take priority over select and enqueue.
REQ-032 occupancy_o SHALL equal the popcount of entry valids; it never exceeds DEPTH and never underflows.

Reset
REQ-033 While core_reset_ni=0 at a clock edge, all entries SHALL be invalidated, with valid_o=0, data_o=0 and occupancy_o=0.
REQ-034 enq_ready_o SHALL be 1 in the first cycle after reset is released.
REQ-035 Reset asserted mid-operation SHALL discard in-flight entries without issuing them.

Structure
REQ-036 Shared package ixu_pkg SHALL hold the entry struct typedef, the physical-register width (6) and the ROB-tag width (6).
REQ-037 A sub-module ixu_sched_select SHALL implement the lowest-index-ready priority select with one-hot grant.

Verification
REQ-038 Empty queue, enqueue lane0 {rob=3, rs1=5 rdy, rs2=0} -> valid_o=1, data_o={0,5,3} exactly 2 cycles after enqueue.
REQ-039 Entry with rs1=9 not ready; wake_dest_i[1]=9 valid in cycle t -> issued on data_o at t+1; an older ready entry wins if present.
REQ-040 Fill to DEPTH=8 with not-ready sources -> enq_ready_o=0 and occupancy_o=8; one wake frees one entry -> enq_ready_o stays 0 until occupancy ≤6.
REQ-041 Three ready entries rob=1,2,3 enqueued in order -> issued in order 1,2,3 on consecutive cycles.
REQ-042 Flush with 5 valid entries and a pending selection -> valid_o=0 the next cycle, occupancy_o=0, and the same-cycle enqueue is dropped.
REQ-043 core_reset_ni=0 for 1 cycle mid-stream -> all outputs 0 the next cycle; no stale rob appears afterwards.
